// File: rtl/dmem_lsu.sv
// dmem_lsu -- load/store unit in front of a word-only data memory.
//
// Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-granular
// mem_read/mem_write cycles. Sub-word stores are done as read-modify-write.
// Loads are sign- or zero-extended.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. The core holds the request until it is taken.
// Each request finishes with a single-cycle resp_valid pulse.
//
// Configuration macro: MISALIGNED_SPLIT_EN
//   defined   : misaligned accesses are carried out. An access that crosses
//               into the next word uses two reads, and for stores two writes.
//   undefined : any misaligned access returns resp_err with no memory write.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I width/sign code
//   req_addr          byte address
//   req_wdata         store data, LSB-aligned
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          misaligned (split disabled) or bad funct3
//   mem_read/write    DMEM strobes, never both high
//   mem_addr          word-aligned DMEM address
//   mem_wdata         DMEM write data
//   mem_rdata         DMEM read data, valid in the same cycle as mem_read
//   dbg_state_o       current FSM state encoding
module dmem_lsu #(
   parameter int ADDR_W     = 32,
   parameter bit BAD_F3_ERR = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [2:0]        dbg_state_o
);

`ifdef MISALIGNED_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

   // Access size: 0 = byte, 1 = halfword, 2 = word. Unused funct3 codes
   // fall into word, so they behave as LW/SW when not flagged as errors.
   function automatic logic [1:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_of = 2'd0;
         2'b01:   size_of = 2'd1;
         default: size_of = 2'd2;
      endcase
   endfunction

   function automatic logic [3:0] lanes_of(input logic [1:0] sz);
      case (sz)
         2'd0:    lanes_of = 4'b0001;
         2'd1:    lanes_of = 4'b0011;
         default: lanes_of = 4'b1111;
      endcase
   endfunction

   function automatic logic is_misal(input logic [1:0] sz, input logic [1:0] off);
      is_misal = (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
   endfunction

   // True when the access runs past byte 3 of its word into word A+4.
   function automatic logic is_span(input logic [1:0] sz, input logic [1:0] off);
      is_span = (sz == 2'd1 && off == 2'd3) || (sz == 2'd2 && off != 2'd0);
   endfunction

   // pair = {upper word, lower word}; shift down to the addressed byte, then extend.
   function automatic logic [31:0] extract(input logic [63:0] pair, input logic [2:0] f3,
                                           input logic [1:0] off);
      logic [63:0] sh;
      sh = pair >> {off, 3'b000};
      case (size_of(f3))
         2'd0:    extract = f3[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'd1:    extract = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: extract = sh[31:0];
      endcase
   endfunction

   // Byte-lane merge across a 64-bit window. The lanes picked by the mask
   // come from the shifted store data. All other lanes keep the old data.
   function automatic logic [63:0] merge(input logic [63:0] old, input logic [31:0] wd,
                                         input logic [2:0] f3, input logic [1:0] off);
      logic [7:0]  mask;
      logic [63:0] data;
      logic [63:0] res;
      mask = {4'b0000, lanes_of(size_of(f3))} << off;
      data = {32'b0, wd} << {off, 3'b000};
      for (int i = 0; i < 8; i++) begin
         res[8*i +: 8] = mask[i] ? data[8*i +: 8] : old[8*i +: 8];
      end
      merge = res;
   endfunction

   state_t              state_q;
   logic                we_q;
   logic [2:0]          f3_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         w0_q;
   logic [31:0]         w1_q;
   logic                resp_valid_q, resp_err_q, mem_read_q, mem_write_q;
   logic [31:0]         resp_rdata_q, mem_wdata_q;
   logic [ADDR_W-1:0]   mem_addr_q;

   // Decode of the request being offered this cycle.
   logic [1:0]          req_sz;
   logic                req_bad, req_err, req_span;
   logic [ADDR_W-1:0]   req_word;

   assign req_sz   = size_of(req_funct3);
   assign req_bad  = BAD_F3_ERR && (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                                    req_funct3 == 3'b111);
   assign req_err  = req_bad || (!SPLIT_EN && is_misal(req_sz, req_addr[1:0]));
   assign req_span = SPLIT_EN && is_span(req_sz, req_addr[1:0]);
   assign req_word = {req_addr[ADDR_W-1:2], 2'b00};

   // Decode of the latched request.
   logic                span_q;
   logic [ADDR_W-1:0]   word_a, word_b;
   logic [63:0]         merged_rd0, merged_rd1;

   assign span_q     = SPLIT_EN && is_span(size_of(f3_q), addr_q[1:0]);
   assign word_a     = {addr_q[ADDR_W-1:2], 2'b00};
   assign word_b     = word_a + ADDR_W'(4);   // wraps modulo 2^ADDR_W
   assign merged_rd0 = merge({32'b0, mem_rdata}, wdata_q, f3_q, addr_q[1:0]);
   assign merged_rd1 = merge({mem_rdata, w0_q}, wdata_q, f3_q, addr_q[1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'b000;
         addr_q       <= '0;
         wdata_q      <= 32'b0;
         w0_q         <= 32'b0;
         w1_q         <= 32'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'b0;
         resp_err_q   <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (req_err) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'b0;
                  end else if (req_we && req_sz == 2'd2 && !req_span) begin
                     // A full aligned word needs no read-back.
                     state_q     <= WR0;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= req_word;
                     mem_wdata_q <= req_wdata;
                  end else begin
                     state_q    <= RD0;
                     mem_read_q <= 1'b1;
                     mem_addr_q <= req_word;
                  end
               end
            end
            RD0: begin
               w0_q <= mem_rdata;
               if (span_q) begin
                  state_q    <= RD1;
                  mem_addr_q <= word_b;
               end else begin
                  mem_read_q <= 1'b0;
                  if (we_q) begin
                     state_q     <= WR0;
                     mem_write_q <= 1'b1;
                     mem_wdata_q <= merged_rd0[31:0];
                  end else begin
                     state_q      <= RESP;
                     mem_addr_q   <= '0;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= extract({32'b0, mem_rdata}, f3_q, addr_q[1:0]);
                  end
               end
            end
            RD1: begin
               mem_read_q <= 1'b0;
               if (we_q) begin
                  state_q     <= WR0;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= word_a;
                  mem_wdata_q <= merged_rd1[31:0];
                  w1_q        <= merged_rd1[63:32];
               end else begin
                  state_q      <= RESP;
                  mem_addr_q   <= '0;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= extract({mem_rdata, w0_q}, f3_q, addr_q[1:0]);
               end
            end
            WR0: begin
               if (span_q) begin
                  state_q     <= WR1;
                  mem_addr_q  <= word_b;
                  mem_wdata_q <= w1_q;
               end else begin
                  state_q      <= RESP;
                  mem_write_q  <= 1'b0;
                  mem_addr_q   <= '0;
                  mem_wdata_q  <= 32'b0;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= 32'b0;
               end
            end
            WR1: begin
               state_q      <= RESP;
               mem_write_q  <= 1'b0;
               mem_addr_q   <= '0;
               mem_wdata_q  <= 32'b0;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= 32'b0;
            end
            RESP: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               resp_rdata_q <= 32'b0;
               resp_err_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu -- directed bench for dmem_lsu.
// The bench owns the word memory that the DUT talks to. It also keeps a
// byte-level reference memory and predicts each response from the RV32I
// load/store rules.
module tb_dmem_lsu;

   localparam bit BAD_F3 = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'b0;
   logic [31:0] req_wdata = 32'b0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   dmem_lsu #(.ADDR_W(32), .BAD_F3_ERR(BAD_F3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
   );

   // ---------------- bench DMEM (word array, combinational read) ----------------
   logic [31:0] dmem [0:255];
   logic        clr_mem = 1'b0;

   assign mem_rdata = dmem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 32'b0;
      end else if (mem_write) begin
         dmem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          resp_cnt = 0;
   logic [31:0] last_rdata;
   logic        last_err;
   logic [32:0] exp_q [$];      // {err, rdata}
   logic [7:0]  ref_b [0:1023];  // byte-level reference memory

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // Single compare process, sampling on the falling edge.
   always @(negedge clk) begin
      logic [32:0] e;
      if (mem_write) wr_cnt++;
      if (mem_read) rd_cnt++;
      if (mem_read || mem_write) begin
         check("mem_rd_wr_excl", {31'b0, mem_read && mem_write}, 32'd0);
         check("mem_addr_align", {30'b0, mem_addr[1:0]}, 32'd0);
      end else begin
         check("mem_idle_addr", mem_addr, 32'd0);
         check("mem_idle_wdata", mem_wdata, 32'd0);
      end
      if (resp_valid) begin
         resp_cnt++;
         last_rdata = resp_rdata;
         last_err   = resp_err;
         if (exp_q.size() == 0) begin
            check("resp_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, e[31:0]);
            check("resp_err", {31'b0, resp_err}, {31'b0, e[32]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;
      clr_mem = 1'b1;
      @(posedge clk); #1;
      clr_mem = 1'b0;
   endtask

   // Issue one request, with a prediction from the reference model. Called at
   // posedge+1 and returns at posedge+1 with the DUT back in IDLE.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat);
      int          n, lat_e, wr_e, rd_e;
      logic        bad, mis, span, err;
      logic [31:0] v;
      logic [9:0]  idx;
      n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      bad  = BAD_F3 && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      mis  = (addr % n) != 0;
      span = (int'(addr[1:0]) + n) > 4;
      err  = bad || (mis && !SPLIT);
      v    = 32'b0;
      if (!err) begin
         for (int i = 0; i < n; i++) begin
            idx = addr[9:0] + 10'(i);
            if (we) ref_b[idx] = wd[8*i +: 8];
            else    v[8*i +: 8] = ref_b[idx];
         end
         if (!we && !f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
         if (!we && !f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      end
      if (err)            begin lat_e = 1; wr_e = 0; rd_e = 0; end
      else if (!we)       begin lat_e = span ? 3 : 2; wr_e = 0; rd_e = span ? 2 : 1; end
      else if (span)      begin lat_e = 5; wr_e = 2; rd_e = 2; end
      else if (n == 4)    begin lat_e = 2; wr_e = 1; rd_e = 0; end
      else                begin lat_e = 3; wr_e = 1; rd_e = 1; end
      exp_q.push_back({err, v});
      wr_cnt = 0;
      rd_cnt = 0;
      check("req_ready_before", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 20);
      #1;
      check("resp_latency", lat, lat_e);
      check("mem_write_count", wr_cnt, wr_e);
      check("mem_read_count", rd_cnt, rd_e);
      @(posedge clk); #1;
      check("req_ready_after", {31'b0, req_ready}, 32'd1);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int lat;
      // reset and memory initialisation
      clear_mem();
      @(negedge clk);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", {31'b0, resp_err}, 32'd0);
      check("rst_mem_read", {31'b0, mem_read}, 32'd0);
      check("rst_mem_write", {31'b0, mem_write}, 32'd0);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: SW then LW
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat);
      check("lit_sw_latency", lat, 32'd2);
      check("lit_word10_sw", dmem[4], 32'hDEADBEEF);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, lat);
      check("lit_lw_data", last_rdata, 32'hDEADBEEF);
      check("lit_lw_latency", lat, 32'd2);

      // 2: SB with read-modify-write, then LB / LBU
      do_req(1'b1, 3'b000, 32'h11, 32'h000000AA, lat);
      check("lit_sb_latency", lat, 32'd3);
      check("lit_word10_sb", dmem[4], 32'hDEADAAEF);
      do_req(1'b0, 3'b000, 32'h11, 32'h0, lat);
      check("lit_lb_data", last_rdata, 32'hFFFFFFAA);
      do_req(1'b0, 3'b100, 32'h11, 32'h0, lat);
      check("lit_lbu_data", last_rdata, 32'h000000AA);

      // 3: SH, then LH from both halves, plus extra extraction patterns
      do_req(1'b1, 3'b001, 32'h12, 32'h00001234, lat);
      check("lit_word10_sh", dmem[4], 32'h1234AAEF);
      do_req(1'b0, 3'b001, 32'h12, 32'h0, lat);
      check("lit_lh_hi", last_rdata, 32'h00001234);
      do_req(1'b0, 3'b001, 32'h10, 32'h0, lat);
      check("lit_lh_lo", last_rdata, 32'hFFFFAAEF);
      do_req(1'b0, 3'b101, 32'h10, 32'h0, lat);
      do_req(1'b0, 3'b000, 32'h10, 32'h0, lat);
      do_req(1'b0, 3'b100, 32'h13, 32'h0, lat);
      do_req(1'b0, 3'b001, 32'h11, 32'h0, lat);   // halfword at offset 1

      // 4: misaligned word access across two words
      do_req(1'b1, 3'b010, 32'h14, 32'h00000055, lat);
      do_req(1'b0, 3'b010, 32'h13, 32'h0, lat);
      if (SPLIT) begin
         check("lit_lw13_data", last_rdata, 32'h00005512);
         check("lit_lw13_err", {31'b0, last_err}, 32'd0);
      end else begin
         check("lit_lw13_data", last_rdata, 32'h0);
         check("lit_lw13_err", {31'b0, last_err}, 32'd1);
      end
      do_req(1'b1, 3'b010, 32'h13, 32'hA1B2C3D4, lat);
      do_req(1'b1, 3'b001, 32'h17, 32'h0000BEEF, lat);
      check("mem_word10_vs_ref", dmem[4], {ref_b[19], ref_b[18], ref_b[17], ref_b[16]});
      check("mem_word14_vs_ref", dmem[5], {ref_b[23], ref_b[22], ref_b[21], ref_b[20]});
      check("mem_word18_vs_ref", dmem[6], {ref_b[27], ref_b[26], ref_b[25], ref_b[24]});

      // 5: reserved funct3 codes
      clear_mem();
      do_req(1'b0, 3'b011, 32'h10, 32'h0, lat);
      check("lit_badf3_latency", lat, 32'd1);
      check("lit_badf3_err", {31'b0, last_err}, 32'd1);
      do_req(1'b1, 3'b110, 32'h10, 32'h12345678, lat);
      check("lit_badf3_st_word", dmem[4], 32'h0);

      // 6: reset during RD0 of SB 0x11
      clear_mem();
      do_req(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, lat);
      wr_cnt = 0;
      resp_cnt = 0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h11; req_wdata = 32'h000000AA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("abort_in_rd0", {31'b0, mem_read}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_mem_read", {31'b0, mem_read}, 32'd0);
      check("abort_req_ready_rst", {31'b0, req_ready}, 32'd1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_req_ready", {31'b0, req_ready}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("abort_mem_writes", wr_cnt, 32'd0);
      check("abort_word10", dmem[4], 32'hCAFEF00D);
      check("abort_no_resp", resp_cnt, 32'd0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, lat);
      check("abort_lw_after", last_rdata, 32'hCAFEF00D);

      check("exp_q_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
